fabric_gsr_ctrl: RTL and testbench

FABRIC_GSR_CTRL -- requirements
Module: fabric_gsr_ctrl

---
 rtl/fabric_gsr_pkg.sv | 20 ++
 rtl/fabric_gsr_ctrl_counter.sv | 26 ++
 rtl/fabric_gsr_ctrl.sv | 100 ++++++++++
 tb/tb_fabric_gsr_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/fabric_gsr_pkg.sv
// fabric_gsr_pkg: state encoding, counter width and pulse-length helper
// shared by the fabric global set/reset controller.
package fabric_gsr_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [2:0] {
        WAIT_CFG,
        GATE,
        PULSE,
        RELEASE,
        RUN
    } gsr_state_e;

    // A zero-length request still produces a one-cycle pulse.
    function automatic logic [CNT_W-1:0] pulse_load(input logic [CNT_W-1:0] len);
        return (len == '0) ? '0 : len - 1'b1;
    endfunction

endpackage

// File: rtl/fabric_gsr_ctrl_counter.sv
// gsr_down_counter: loadable down counter that stops at zero and flags
// the last cycle of a timed state.
module gsr_down_counter
    import fabric_gsr_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_term
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_load_val;
        else if (r_cnt != '0)
            r_cnt <= r_cnt - 1'b1;
    end

    assign o_term = (r_cnt == '0);

endmodule

// File: rtl/fabric_gsr_ctrl.sv
// fabric_gsr_ctrl: sequences clock gating and global set/reset pulses for
// the fabric flip-flops around configuration load and re-init requests.
module fabric_gsr_ctrl
    import fabric_gsr_pkg::*;
#(
    parameter int unsigned SETTLE_CYC = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cfg_done,
    input  logic       init_req,
    input  logic       init_mode,
    input  logic [3:0] pulse_len,
    output logic       fab_set,
    output logic       fab_reset,
    output logic       fab_clk_en,
    output logic       init_busy,
    output logic       init_done
);

    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);

    gsr_state_e       r_state;
    gsr_state_e       w_next;
    logic             r_mode;
    logic [CNT_W-1:0] r_len;
    logic             w_load;
    logic [CNT_W-1:0] w_load_val;
    logic             w_term;

    gsr_down_counter u_cnt (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_term     (w_term)
    );

    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_load_val = '0;
        case (r_state)
            WAIT_CFG: begin
                w_next     = RELEASE;
                w_load     = 1'b1;
                w_load_val = SETTLE_LD;
            end
            RUN: if (init_req) begin
                w_next     = GATE;
                w_load     = 1'b1;
                w_load_val = SETTLE_LD;
            end
            GATE: if (w_term) begin
                w_next     = PULSE;
                w_load     = 1'b1;
                w_load_val = pulse_load(r_len);
            end
            PULSE: if (w_term) begin
                w_next     = RELEASE;
                w_load     = 1'b1;
                w_load_val = SETTLE_LD;
            end
            RELEASE: if (w_term) w_next = RUN;
            default: w_next = WAIT_CFG;
        endcase
        // Losing configuration beats every other transition.
        if (!cfg_done) begin
            w_next     = WAIT_CFG;
            w_load     = 1'b1;
            w_load_val = '0;
        end
    end

    // Outputs are registered from the next state so they line up with r_state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= WAIT_CFG;
            r_mode     <= 1'b0;
            r_len      <= '0;
            fab_set    <= 1'b0;
            fab_reset  <= 1'b1;
            fab_clk_en <= 1'b0;
            init_busy  <= 1'b1;
            init_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == RUN && w_next == GATE) begin
                r_mode <= init_mode;
                r_len  <= pulse_len;
            end
            fab_set    <= (w_next == PULSE) && r_mode;
            fab_reset  <= (w_next == WAIT_CFG) || ((w_next == PULSE) && !r_mode);
            fab_clk_en <= (w_next == RUN);
            init_busy  <= (w_next != RUN);
            init_done  <= (w_next == RUN) && (r_state == RELEASE);
        end
    end

endmodule

// File: tb/tb_fabric_gsr_ctrl.sv
// tb_fabric_gsr_ctrl: directed and randomized checks of fabric_gsr_ctrl
// against a schedule-based model of expected output cycles.
module tb_fabric_gsr_ctrl;

    localparam int S = 2;
    // Output tuples {fab_set, fab_reset, fab_clk_en, init_busy, init_done}
    localparam logic [4:0] V_WAIT = 5'b01010;
    localparam logic [4:0] V_GAP  = 5'b00010;
    localparam logic [4:0] V_SET  = 5'b10010;
    localparam logic [4:0] V_RST  = 5'b01010;
    localparam logic [4:0] V_RUN  = 5'b00100;
    localparam logic [4:0] V_DONE = 5'b00101;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cfg_done = 1'b0;
    logic       init_req = 1'b0;
    logic       init_mode = 1'b0;
    logic [3:0] pulse_len = 4'd0;
    logic       fab_set, fab_reset, fab_clk_en, init_busy, init_done;
    logic [4:0] w_out;
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    fabric_gsr_ctrl #(.SETTLE_CYC(S)) dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_done   (cfg_done),
        .init_req   (init_req),
        .init_mode  (init_mode),
        .pulse_len  (pulse_len),
        .fab_set    (fab_set),
        .fab_reset  (fab_reset),
        .fab_clk_en (fab_clk_en),
        .init_busy  (init_busy),
        .init_done  (init_done)
    );

    assign w_out = {fab_set, fab_reset, fab_clk_en, init_busy, init_done};

    // Model: a queue of the output tuples still owed by the sequence in progress.
    logic [4:0] q[$];
    logic [4:0] exp_v = V_WAIT;
    bit         running = 1'b0;
    bit         forced = 1'b1;
    int         m_len;

    always @(posedge clk or posedge reset) begin
        if (reset || !cfg_done) begin
            q.delete();
            running = 1'b0;
            forced = 1'b1;
            exp_v = V_WAIT;
        end else begin
            forced = 1'b0;
            if (q.size() == 0 && !running) begin
                repeat (S) q.push_back(V_GAP);
                q.push_back(V_DONE);
            end else if (q.size() == 0 && init_req) begin
                m_len = (pulse_len == 4'd0) ? 1 : int'(pulse_len);
                repeat (S) q.push_back(V_GAP);
                repeat (m_len) q.push_back(init_mode ? V_SET : V_RST);
                repeat (S) q.push_back(V_GAP);
                q.push_back(V_DONE);
            end
            if (q.size() != 0) begin
                exp_v = q.pop_front();
                if (exp_v == V_DONE) running = 1'b1;
            end else begin
                exp_v = V_RUN;
            end
        end
    end

    logic [1:0] prev_sr = 2'b01;
    int         since_en = 100;
    int         quiet = 0;

    always @(negedge clk) begin
        if (reset) begin
            prev_sr = 2'b01;
            since_en = 100;
            quiet = 0;
        end else begin
            n_cmp++;
            if (w_out !== exp_v) begin
                n_bad++;
                $display("FAIL model t=%0t: got %b expected %b", $time, w_out, exp_v);
            end
            n_cmp++;
            since_en = fab_clk_en ? 0 : since_en + 1;
            if (|(prev_sr & ~{fab_set, fab_reset})) quiet = S;
            if ((fab_set && fab_reset) || ((fab_set || fab_reset) && fab_clk_en) ||
                (quiet > 0 && fab_clk_en) ||
                (|({fab_set, fab_reset} & ~prev_sr) && !forced && since_en <= S)) begin
                n_bad++;
                $display("FAIL safety t=%0t: set=%b reset=%b clk_en=%b since_en=%0d required exclusive and gated",
                         $time, fab_set, fab_reset, fab_clk_en, since_en);
            end
            if (quiet > 0) quiet--;
            prev_sr = {fab_set, fab_reset};
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [4:0] got, input logic [4:0] e);
        n_cmp++;
        if (got !== e) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", nm, got, e);
        end
    endtask

    task automatic exp_seq(input string nm, input int n, input logic [59:0] s);
        for (int i = 0; i < n; i++) begin
            if (i > 0) tick();
            chk($sformatf("%s[%0d]", nm, i), w_out, s[5*(n-1-i) +: 5]);
        end
    endtask

    task automatic trig(input logic m, input logic [3:0] l);
        #1 init_req = 1'b1;
        init_mode = m;
        pulse_len = l;
        tick();
        #1 init_req = 1'b0;
    endtask

    initial begin
        repeat (3) tick();
        chk("reset_state", w_out, V_WAIT);
        #1 reset = 1'b0;
        repeat (10) tick();
        chk("wait_cfg_hold", w_out, V_WAIT);
        #1 cfg_done = 1'b1;
        tick();
        exp_seq("cfg_bringup", 4, 60'({V_GAP, V_GAP, V_DONE, V_RUN}));
        trig(1'b1, 4'd3);
        exp_seq("set_len3", 9, 60'({V_GAP, V_GAP, V_SET, V_SET, V_SET, V_GAP, V_GAP, V_DONE, V_RUN}));
        trig(1'b0, 4'd0);
        exp_seq("clr_len0", 7, 60'({V_GAP, V_GAP, V_RST, V_GAP, V_GAP, V_DONE, V_RUN}));
        trig(1'b1, 4'd3);
        exp_seq("drop_pre", 4, 60'({V_GAP, V_GAP, V_SET, V_SET}));
        #1 cfg_done = 1'b0;
        tick();
        exp_seq("drop_wait", 4, 60'({V_WAIT, V_WAIT, V_WAIT, V_WAIT}));
        #1 cfg_done = 1'b1;
        tick();
        exp_seq("recover", 4, 60'({V_GAP, V_GAP, V_DONE, V_RUN}));
        trig(1'b0, 4'd2);
        chk("gate1", w_out, V_GAP);
        tick();
        #1 init_req = 1'b1;
        tick();
        chk("pulse1", w_out, V_RST);
        #1 init_req = 1'b0;
        init_mode = 1'b1;
        pulse_len = 4'd7;
        tick();
        exp_seq("hold_mode", 6, 60'({V_RST, V_GAP, V_GAP, V_DONE, V_RUN, V_RUN}));
        trig(1'b0, 4'd1);
        exp_seq("pre_reset", 4, 60'({V_GAP, V_GAP, V_RST, V_GAP}));
        #2 reset = 1'b1;
        #1 chk("async_reset", w_out, V_WAIT);
        tick();
        #1 reset = 1'b0;
        tick();
        exp_seq("post_reset", 4, 60'({V_GAP, V_GAP, V_DONE, V_RUN}));
        repeat (3000) begin
            #1 cfg_done = ($urandom_range(0, 40) != 0);
            init_req = ($urandom_range(0, 3) == 0);
            init_mode = 1'($urandom);
            pulse_len = 4'($urandom);
            reset = ($urandom_range(0, 300) == 0);
            tick();
        end
        #1 reset = 1'b0;
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
